// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit combinational full adder cell shared by the serial datapath.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one full_adder LSB-first over WIDTH bits, one bit per clock.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_a_q, sh_a_d;
    logic [WIDTH-1:0]   sh_b_q, sh_b_d;
    logic [WIDTH-2:0]   sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cout_q, cout_d;
    logic               fa_s, fa_cout;
    logic [WIDTH-1:0]   sum_full;
    logic               last_bit;

    full_adder u_fa (
        .A    (sh_a_q[0]),
        .B    (sh_b_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // The collect register holds only the WIDTH-1 bits finished so far; the
    // bit produced this cycle completes the word.
    assign sum_full = {fa_s, sum_sh_q};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cout_d   = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_a_d  = a;
                    sh_b_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sh_a_d   = sh_a_q >> 1;
                sh_b_d   = sh_b_q >> 1;
                sum_sh_d = sum_full[WIDTH-1:1];
                carry_d  = fa_cout;
                cnt_d    = last_bit ? cnt_q : cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d   = sum_full;
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that shares the single-bit full_adder cell across all bit positions of a WIDTH-bit addition, one bit per clock. It latches operands on a start pulse, sequences LSB-first through the full_adder, collects sum bits, and signals completion with a one-cycle done pulse. It is the sequencing layer above the combinational full_adder in the lab datapath.

Parameters:
WIDTH, 8, operand/sum width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new addition; sampled only in IDLE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  result, held stable from done until the next accepted start
cout  output  1  final carry-out, held with sum

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset, sampled on a clk edge: state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry register and counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> capture a/b into shift regs sh_a/sh_b, carry_q<=cin, cnt<=0, go RUN. start=0 -> stay; sum/cout hold their last values.
- RUN, once per cycle: full_adder inputs are sh_a[0], sh_b[0], carry_q. sum shift reg <= {S, sum_sh[WIDTH-1:1]}, i.e. LSB-first fill from the top. sh_a/sh_b shift right with zero fill. carry_q<=Cout. cnt<=cnt+1.
- RUN -> DONE on the cycle where cnt==WIDTH-1, after the last bit is processed.
- DONE: done=1 for exactly one cycle. sum=completed shift reg and cout=carry_q are valid in this cycle. Unconditional return to IDLE next cycle.
- Latency: start accepted at edge k -> done high during cycle k+WIDTH+1. Throughput: one addition per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored; there is no queueing. Operand changes during RUN have no effect.
- Arithmetic: {cout,sum} == a + b + cin modulo 2^(WIDTH+1), exact.
- sum/cout visible at the ports are updated only on entry to DONE. They do not show partial results during RUN and keep the previous result until then.
- rst asserted mid-RUN: abort immediately to reset values, with no done pulse. start in the same cycle as rst is ignored.
- cnt must not wrap. It covers 0..WIDTH-1 with CNT_W bits.

Decomposition:
- Shared package serial_adder_pkg: state encoding constants (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2).
- One sub-module: the existing full_adder (ports A, B, Cin, S, Cout), instantiated once as the only arithmetic element. No other adder logic is permitted.
- Datapath registers and FSM stay in serial_adder_ctrl.

Test Plan:
- rst held 2 cycles, then released -> busy=0, done=0, sum=8'h00, cout=0; no done pulse for 20 idle cycles.
- WIDTH=8: a=8'h35, b=8'h4A, cin=0, start pulsed 1 cycle -> busy high next cycle; done pulse exactly 9 cycles after the start edge; sum=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start re-pulsed at cycles 3 and 8 of a RUN (a=8'h10, b=8'h20), with operands changed to 8'hAA/8'h55 at those pulses -> single done; sum=8'h30; both re-pulses ignored.
- rst asserted at cycle 4 of RUN -> next cycle busy=0, sum=0, cout=0, no done. A following start with a=8'h01, b=8'h02, cin=1 -> sum=8'h04.
- Random 500 vectors with back-to-back starts issued the cycle after each done -> every {cout,sum} matches a+b+cin; inter-done spacing is exactly 10 cycles.
